// File: rtl/tennis_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tennis_pkg : shared referee state type and board constants, 16-LED tennis
// Rev 1.0
// ---------------------------------------------------------------------------
package tennis_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RALLY    = 3'd1,
    POINT    = 3'd2,
    WAIT_CLR = 3'd3,
    OVER     = 3'd4
  } state_e;

  localparam int DEFAULT_WIN_SCORE = 7;

  localparam logic [15:0] S1  = 16'h8000;
  localparam logic [15:0] S16 = 16'h0001;

endpackage
`default_nettype wire

// File: rtl/rally_referee_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_detect : registered-history rise/fall detector for one level input
// Rev 1.0
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule
`default_nettype wire

// File: rtl/rally_referee.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rally_referee : judges hits/misses, keeps both scores, declares the winner
// Rev 1.0
// ---------------------------------------------------------------------------
module rally_referee
  import tennis_pkg::*;
#(
  parameter int WIN_SCORE = DEFAULT_WIN_SCORE,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               button_one,
  input  logic               button_two,
  input  logic [15:0]        pos,
  input  logic               hittable_one,
  input  logic               hittable_two,
  input  logic               start_game,
  output logic               return_one,
  output logic               return_two,
  output logic               match_one,
  output logic               match_two,
  output logic [SCORE_W-1:0] score_one,
  output logic [SCORE_W-1:0] score_two,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] C_WIN = SCORE_W'(WIN_SCORE);

  // Index order: 0 = button_one, 1 = button_two, 2 = hittable_one, 3 = hittable_two
  logic [3:0] src_w, rise_w, fall_w;
  assign src_w = {hittable_two, hittable_one, button_two, button_one};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      edge_detect u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (src_w[gi]),
        .rise (rise_w[gi]),
        .fall (fall_w[gi])
      );
    end
  endgenerate

  logic unused_pos;
  assign unused_pos = ^pos;

  state_e             state_q, state_d;
  logic               hit_done_one_q, hit_done_one_d, hit_done_two_q, hit_done_two_d;
  logic               return_one_q, return_one_d, return_two_q, return_two_d;
  logic               match_one_q, match_one_d, match_two_q, match_two_d;
  logic [SCORE_W-1:0] score_one_q, score_one_d, score_two_q, score_two_d;
  logic               game_over_q, game_over_d, winner_q, winner_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      hit_done_one_q <= 1'b0;
      hit_done_two_q <= 1'b0;
      return_one_q   <= 1'b0;
      return_two_q   <= 1'b0;
      match_one_q    <= 1'b0;
      match_two_q    <= 1'b0;
      score_one_q    <= '0;
      score_two_q    <= '0;
      game_over_q    <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      hit_done_one_q <= hit_done_one_d;
      hit_done_two_q <= hit_done_two_d;
      return_one_q   <= return_one_d;
      return_two_q   <= return_two_d;
      match_one_q    <= match_one_d;
      match_two_q    <= match_two_d;
      score_one_q    <= score_one_d;
      score_two_q    <= score_two_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    hit_done_one_d = hit_done_one_q;
    hit_done_two_d = hit_done_two_q;
    return_one_d   = 1'b0;
    return_two_d   = 1'b0;
    match_one_d    = 1'b0;
    match_two_d    = 1'b0;
    score_one_d    = score_one_q;
    score_two_d    = score_two_q;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    case (state_q)
      IDLE: begin
        hit_done_one_d = 1'b0;
        hit_done_two_d = 1'b0;
        if (start_game) state_d = RALLY;
      end
      RALLY: begin
        if (rise_w[0] && hittable_one && !hit_done_one_q) begin
          hit_done_one_d = 1'b1;
          return_one_d   = 1'b1;
        end
        if (rise_w[1] && hittable_two && !hit_done_two_q) begin
          hit_done_two_d = 1'b1;
          return_two_d   = 1'b1;
        end
        if (fall_w[2]) hit_done_one_d = 1'b0;
        if (fall_w[3]) hit_done_two_d = 1'b0;
        // A player-one miss wins over a simultaneous player-two miss.
        if (fall_w[2] && !hit_done_one_q) begin
          match_two_d = 1'b1;
          score_two_d = (score_two_q < C_WIN) ? score_two_q + SCORE_W'(1) : score_two_q;
          state_d     = POINT;
        end else if (fall_w[3] && !hit_done_two_q) begin
          match_one_d = 1'b1;
          score_one_d = (score_one_q < C_WIN) ? score_one_q + SCORE_W'(1) : score_one_q;
          state_d     = POINT;
        end
      end
      POINT: begin
        hit_done_one_d = 1'b0;
        hit_done_two_d = 1'b0;
        if (score_one_q == C_WIN || score_two_q == C_WIN) begin
          state_d     = OVER;
          game_over_d = 1'b1;
          winner_d    = (score_two_q == C_WIN);
        end else begin
          state_d = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!start_game) state_d = IDLE;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  assign return_one = return_one_q;
  assign return_two = return_two_q;
  assign match_one  = match_one_q;
  assign match_two  = match_two_q;
  assign score_one  = score_one_q;
  assign score_two  = score_two_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_rally_referee.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rally_referee : vector table, directed corner sequences, random vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rally_referee;

  localparam int WIN = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b1 = 0, b2 = 0, h1 = 0, h2 = 0, sg = 0;
  logic [15:0] pos = 16'h0;
  logic        return_one, return_two, match_one, match_two, game_over, winner;
  logic [3:0]  score_one, score_two;

  int n_cmp = 0;
  int n_fail = 0;

  rally_referee #(.WIN_SCORE(WIN), .SCORE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .button_one(b1), .button_two(b2), .pos(pos),
    .hittable_one(h1), .hittable_two(h2), .start_game(sg),
    .return_one(return_one), .return_two(return_two),
    .match_one(match_one), .match_two(match_two),
    .score_one(score_one), .score_two(score_two),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // {r1, r2, m1, m2, s1[3:0], s2[3:0], game_over, winner}
  function automatic logic [13:0] pk(input logic r1, r2, m1, m2, input int s1, s2,
                                     input logic go, w);
    return {r1, r2, m1, m2, 4'(s1), 4'(s2), go, w};
  endfunction

  function automatic logic [13:0] dut_out();
    return {return_one, return_two, match_one, match_two, score_one, score_two,
            game_over, winner};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ib1, ib2, ih1, ih2, isg);
    b1 = ib1; b2 = ib2; h1 = ih1; h2 = ih2; sg = isg;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- table of directed vectors ----------------
  typedef struct {
    logic        b1, b2, h1, h2, sg;
    logic [13:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic ib1, ib2, ih1, ih2, isg,
                              input logic r1, r2, m1, m2, input int s1, s2);
    vec_t v;
    v.b1 = ib1; v.b2 = ib2; v.h1 = ih1; v.h2 = ih2; v.sg = isg;
    v.exp = pk(r1, r2, m1, m2, s1, s2, 1'b0, 1'b0);
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Play state: 0 waiting for serve, 1 rally, 2 point just awarded,
  // 3 waiting for serve release, 4 game finished.
  int   m_play;
  bit   m_done1, m_done2, m_pb1, m_pb2, m_ph1, m_ph2, m_go, m_win;
  int   m_s1, m_s2;
  logic [13:0] m_exp;

  function automatic void model_reset();
    m_play = 0; m_done1 = 0; m_done2 = 0;
    m_pb1 = 0; m_pb2 = 0; m_ph1 = 0; m_ph2 = 0;
    m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0;
    m_exp = '0;
  endfunction

  function automatic void model_step(input bit ib1, ib2, ih1, ih2, isg);
    bit press1, press2, close1, close2, r1, r2, m1, m2;
    press1 = ib1 && !m_pb1;  press2 = ib2 && !m_pb2;
    close1 = !ih1 && m_ph1;  close2 = !ih2 && m_ph2;
    r1 = 0; r2 = 0; m1 = 0; m2 = 0;
    if (m_play == 0) begin
      m_done1 = 0; m_done2 = 0;
      if (isg) m_play = 1;
    end else if (m_play == 1) begin
      bit miss1, miss2;
      miss1 = close1 && !m_done1;
      miss2 = close2 && !m_done2;
      if (press1 && ih1 && !m_done1) begin m_done1 = 1; r1 = 1; end
      if (press2 && ih2 && !m_done2) begin m_done2 = 1; r2 = 1; end
      if (close1) m_done1 = 0;
      if (close2) m_done2 = 0;
      if (miss1) begin
        m2 = 1; m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; m_play = 2;
      end else if (miss2) begin
        m1 = 1; m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; m_play = 2;
      end
    end else if (m_play == 2) begin
      m_done1 = 0; m_done2 = 0;
      if (m_s1 == WIN || m_s2 == WIN) begin
        m_play = 4; m_go = 1; m_win = (m_s2 == WIN);
      end else begin
        m_play = 3;
      end
    end else if (m_play == 3) begin
      if (!isg) m_play = 0;
    end
    m_pb1 = ib1; m_pb2 = ib2; m_ph1 = ih1; m_ph2 = ih2;
    m_exp = pk(r1, r2, m1, m2, m_s1, m_s2, m_go, m_win);
  endfunction

  initial begin
    vec_t tbl[22];
    int   ret2_cnt, match_cnt, pulse_cnt;
    int   win_sel;

    tbl[0]  = mk(0,0,0,0,1, 0,0,0,0, 0,0);
    tbl[1]  = mk(0,0,1,0,1, 0,0,0,0, 0,0);
    tbl[2]  = mk(1,0,1,0,1, 1,0,0,0, 0,0);
    tbl[3]  = mk(1,0,1,0,1, 0,0,0,0, 0,0);
    tbl[4]  = mk(0,0,0,0,1, 0,0,0,0, 0,0);
    tbl[5]  = mk(0,0,0,1,1, 0,0,0,0, 0,0);
    tbl[6]  = mk(0,0,0,0,1, 0,0,1,0, 1,0);
    tbl[7]  = mk(0,0,0,0,1, 0,0,0,0, 1,0);
    tbl[8]  = mk(0,0,0,0,0, 0,0,0,0, 1,0);
    tbl[9]  = mk(0,0,0,0,1, 0,0,0,0, 1,0);
    tbl[10] = mk(1,0,1,0,1, 1,0,0,0, 1,0);
    tbl[11] = mk(0,0,0,0,1, 0,0,0,0, 1,0);
    tbl[12] = mk(0,1,0,1,1, 0,1,0,0, 1,0);
    tbl[13] = mk(0,0,0,1,1, 0,0,0,0, 1,0);
    tbl[14] = mk(0,1,0,1,1, 0,0,0,0, 1,0);
    tbl[15] = mk(0,0,0,0,1, 0,0,0,0, 1,0);
    tbl[16] = mk(0,0,1,0,1, 0,0,0,0, 1,0);
    tbl[17] = mk(1,0,0,0,1, 0,0,0,1, 1,1);
    tbl[18] = mk(0,0,0,0,0, 0,0,0,0, 1,1);
    tbl[19] = mk(0,0,0,0,0, 0,0,0,0, 1,1);
    tbl[20] = mk(0,1,0,0,1, 0,0,0,0, 1,1);
    tbl[21] = mk(0,0,0,1,1, 0,0,0,0, 1,1);

    // Reset state
    #2;
    chk("reset_outputs", 32'(dut_out()), 32'(pk(0,0,0,0,0,0,0,0)));
    do_reset();
    tick();
    chk("post_reset_outputs", 32'(dut_out()), 32'(pk(0,0,0,0,0,0,0,0)));

    // Vector table
    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].b1, tbl[i].b2, tbl[i].h1, tbl[i].h2, tbl[i].sg);
      tick();
      chk($sformatf("table[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Good return by player two: press 3 cycles into window, close 10 later
    do_reset();
    ret2_cnt = 0; match_cnt = 0;
    set_in(0,0,0,0,1); tick();
    set_in(0,0,0,1,1); tick();
    for (int c = 0; c < 16; c++) begin
      b2 = (c == 2);
      h2 = (c < 12);
      tick();
      ret2_cnt += int'(return_two);
      match_cnt += int'(match_one) + int'(match_two);
    end
    chk("good_return_pulses", 32'(ret2_cnt), 32'd1);
    chk("good_return_no_match", 32'(match_cnt), 32'd0);
    chk("good_return_scores", 32'({score_one, score_two}), 32'h00);

    // Player one wins seven points in a row
    do_reset();
    for (int k = 0; k < WIN; k++) begin
      set_in(0,0,0,0,1); tick();
      set_in(0,0,0,1,1); tick();
      set_in(0,0,0,0,1); tick();
      chk($sformatf("game_point%0d_match_one", k), 32'({match_one, match_two}), 32'b10);
      chk($sformatf("game_point%0d_score_one", k), 32'(score_one), 32'(k + 1));
      set_in(0,0,0,0,0); tick();
      set_in(0,0,0,0,0); tick();
    end
    chk("game_end_state", 32'({score_one, score_two, game_over, winner}),
        32'({4'd7, 4'd0, 1'b1, 1'b0}));
    pulse_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      set_in(c[0], c[1], c[2], ~c[2], c[3] | c[0]);
      tick();
      pulse_cnt += int'(return_one) + int'(return_two) + int'(match_one) + int'(match_two);
    end
    chk("over_no_pulses", 32'(pulse_cnt), 32'd0);
    chk("over_frozen", 32'({score_one, score_two, game_over, winner}),
        32'({4'd7, 4'd0, 1'b1, 1'b0}));

    // Reset while the point pulse is high
    do_reset();
    set_in(0,0,0,0,1); tick();
    set_in(0,0,0,1,1); tick();
    set_in(0,0,0,0,1); tick();
    chk("rst_point_match_one", 32'({match_one, score_one}), 32'({1'b1, 4'd1}));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_point_async_clear", 32'(dut_out()), 32'(pk(0,0,0,0,0,0,0,0)));
    tick();
    rst_n = 1'b1;
    set_in(0,0,0,0,0); tick();
    chk("rst_point_after_release", 32'(dut_out()), 32'(pk(0,0,0,0,0,0,0,0)));
    set_in(0,0,1,0,1); tick();
    set_in(0,0,0,0,1); tick();
    chk("rst_point_new_rally", 32'(dut_out()), 32'(pk(0,0,0,1,0,1,0,0)));

    // Randomized stimulus against the reference model
    win_sel = 0;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 300; c++) begin
        logic rb1, rb2, rsg;
        if ($urandom_range(0, 3) == 0) win_sel = $urandom_range(0, 2);
        rb1 = ($urandom_range(0, 2) == 0);
        rb2 = ($urandom_range(0, 2) == 0);
        rsg = (c % 16 < 13) ? ($urandom_range(0, 9) != 0) : 1'b0;
        set_in(rb1, rb2, win_sel == 1, win_sel == 2, rsg);
        model_step(rb1, rb2, win_sel == 1, win_sel == 2, rsg);
        tick();
        chk($sformatf("random seg%0d cyc%0d", seg, c), 32'(dut_out()), 32'(m_exp));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
